// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants and the in-flight destination record used by
// the operand forwarding / interlock controller.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;

    localparam logic [5:0] F_SLL     = 6'b000000;
    localparam logic [5:0] F_SRL     = 6'b000010;
    localparam logic [5:0] F_SRA     = 6'b000011;
    localparam logic [5:0] F_SRLV    = 6'b000110;
    localparam logic [5:0] F_SRAV    = 6'b000111;
    localparam logic [5:0] F_JR      = 6'b001000;
    localparam logic [5:0] F_SYSCALL = 6'b001100;
    localparam logic [5:0] F_ADD     = 6'b100000;
    localparam logic [5:0] F_ADDU    = 6'b100001;
    localparam logic [5:0] F_SUB     = 6'b100010;
    localparam logic [5:0] F_AND     = 6'b100100;
    localparam logic [5:0] F_OR      = 6'b100101;
    localparam logic [5:0] F_NOR     = 6'b100111;
    localparam logic [5:0] F_SLT     = 6'b101010;
    localparam logic [5:0] F_SLTU    = 6'b101011;

    localparam int DEC_AW = 5;

    localparam logic [DEC_AW-1:0] REG_ZERO = 5'd0;
    localparam logic [DEC_AW-1:0] REG_V0   = 5'd2;
    localparam logic [DEC_AW-1:0] REG_A0   = 5'd4;
    localparam logic [DEC_AW-1:0] REG_RA   = 5'd31;

    typedef struct packed {
        logic              valid;
        logic [DEC_AW-1:0] dest;
        logic              is_load;
    } fwd_entry_t;

    function automatic logic is_store(input logic [5:0] op);
        return (op[5:3] == 3'b101);
    endfunction

endpackage

// File: rtl/operand_fwd_ctrl_decode.sv
// Combinational source/destination decode of one MIPS instruction: read-port
// addresses with used flags, plus the destination register and load flag.
module instr_reg_decode
    import mips_pkg::*;
(
    input  logic [31:0]       instr,
    output logic [DEC_AW-1:0] ra_addr,
    output logic [DEC_AW-1:0] rb_addr,
    output logic              ra_used,
    output logic              rb_used,
    output logic [DEC_AW-1:0] dest,
    output logic              wr_en,
    output logic              is_load
);

    logic [5:0]        op_s;
    logic [5:0]        funct_s;
    logic [DEC_AW-1:0] rs_s;
    logic [DEC_AW-1:0] rt_s;
    logic [DEC_AW-1:0] rd_s;
    logic [DEC_AW-1:0] dest_raw_s;
    logic              load_s;
    logic              unused_shamt_s;

    assign op_s           = instr[31:26];
    assign funct_s        = instr[5:0];
    assign rs_s           = instr[25:21];
    assign rt_s           = instr[20:16];
    assign rd_s           = instr[15:11];
    assign unused_shamt_s = ^instr[10:6];

    // Source ports and raw destination per instruction class
    always_comb begin
        ra_addr    = rs_s;
        rb_addr    = rt_s;
        ra_used    = 1'b0;
        rb_used    = 1'b0;
        dest_raw_s = REG_ZERO;
        load_s     = 1'b0;
        case (op_s)
            OP_RTYPE: begin
                dest_raw_s = rd_s;
                case (funct_s)
                    F_ADD, F_ADDU, F_SUB, F_AND, F_OR, F_NOR, F_SLT, F_SLTU: begin
                        ra_used = 1'b1;
                        rb_used = 1'b1;
                    end
                    F_SLL, F_SRL, F_SRA: begin
                        ra_addr = rt_s;
                        ra_used = 1'b1;
                    end
                    F_SRLV, F_SRAV: begin
                        ra_addr = rt_s;
                        rb_addr = rs_s;
                        ra_used = 1'b1;
                        rb_used = 1'b1;
                    end
                    F_JR: begin
                        ra_used    = 1'b1;
                        dest_raw_s = REG_ZERO;
                    end
                    F_SYSCALL: begin
                        ra_addr    = REG_V0;
                        rb_addr    = REG_A0;
                        ra_used    = 1'b1;
                        rb_used    = 1'b1;
                        dest_raw_s = REG_ZERO;
                    end
                    default: begin
                        ra_used = 1'b0;
                    end
                endcase
            end
            OP_J: begin
                dest_raw_s = REG_ZERO;
            end
            OP_JAL: begin
                dest_raw_s = REG_RA;
            end
            default: begin
                ra_used = (op_s != OP_LUI);
                rb_used = is_store(op_s) || (op_s == OP_BEQ) || (op_s == OP_BNE);
                case (op_s)
                    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                        dest_raw_s = rt_s;
                        load_s     = 1'b1;
                    end
                    default: begin
                        // addi..lui write rt; everything else has no destination
                        dest_raw_s = (op_s[5:3] == 3'b001) ? rt_s : REG_ZERO;
                    end
                endcase
            end
        endcase
    end

    assign dest    = dest_raw_s;
    assign wr_en   = (dest_raw_s != REG_ZERO);
    assign is_load = load_s & wr_en;

endmodule

// File: rtl/operand_fwd_ctrl.sv
// ID-stage register-read select, forwarding select and load-use interlock,
// driven by a shadow pipe of in-flight destinations (entry 1 = EX).
module operand_fwd_ctrl
    import mips_pkg::*;
#(
    parameter int NUM_FWD_STAGES = 3,
    parameter int LOAD_READY     = 2,
    parameter int REG_AW         = 5,
    parameter int FWD_W          = $clog2(NUM_FWD_STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [31:0]       id_instr,
    input  logic              stall_in,
    input  logic              flush,
    output logic [REG_AW-1:0] ra_addr,
    output logic [REG_AW-1:0] rb_addr,
    output logic              ra_used,
    output logic              rb_used,
    output logic [FWD_W-1:0]  fwd_a,
    output logic [FWD_W-1:0]  fwd_b,
    output logic              hazard_stall,
    output logic              issue,
    output logic [15:0]       stall_cnt
);

    logic [DEC_AW-1:0] dec_ra_s;
    logic [DEC_AW-1:0] dec_rb_s;
    logic              dec_ra_used_s;
    logic              dec_rb_used_s;
    logic [DEC_AW-1:0] dec_dest_s;
    logic              dec_wr_en_s;
    logic              dec_is_load_s;

    fwd_entry_t        pipe_q [1:NUM_FWD_STAGES];
    fwd_entry_t        pipe_d [1:NUM_FWD_STAGES];
    logic [15:0]       stall_cnt_q;
    logic [15:0]       stall_cnt_d;

    logic [FWD_W-1:0]  fwd_a_s;
    logic [FWD_W-1:0]  fwd_b_s;
    logic              ld_hz_s;

    instr_reg_decode u_dec (
        .instr   (id_instr),
        .ra_addr (dec_ra_s),
        .rb_addr (dec_rb_s),
        .ra_used (dec_ra_used_s),
        .rb_used (dec_rb_used_s),
        .dest    (dec_dest_s),
        .wr_en   (dec_wr_en_s),
        .is_load (dec_is_load_s)
    );

    // Scan oldest to youngest so the youngest matching stage wins
    always_comb begin
        fwd_a_s = '0;
        fwd_b_s = '0;
        ld_hz_s = 1'b0;
        for (int k = NUM_FWD_STAGES; k >= 1; k--) begin
            logic hit_a;
            logic hit_b;
            hit_a   = pipe_q[k].valid && dec_ra_used_s && (dec_ra_s != REG_ZERO)
                      && (pipe_q[k].dest == dec_ra_s);
            hit_b   = pipe_q[k].valid && dec_rb_used_s && (dec_rb_s != REG_ZERO)
                      && (pipe_q[k].dest == dec_rb_s);
            fwd_a_s = hit_a ? FWD_W'(k) : fwd_a_s;
            fwd_b_s = hit_b ? FWD_W'(k) : fwd_b_s;
            ld_hz_s = ld_hz_s | ((hit_a | hit_b) & pipe_q[k].is_load & (k < LOAD_READY));
        end
    end

    assign ra_addr      = REG_AW'(dec_ra_s);
    assign rb_addr      = REG_AW'(dec_rb_s);
    assign ra_used      = dec_ra_used_s;
    assign rb_used      = dec_rb_used_s;
    assign hazard_stall = rst_n & id_valid & ~flush & ld_hz_s;
    assign issue        = rst_n & id_valid & ~hazard_stall & ~flush & ~stall_in;
    assign fwd_a        = rst_n ? fwd_a_s : '0;
    assign fwd_b        = rst_n ? fwd_b_s : '0;
    assign stall_cnt    = stall_cnt_q;

    // Next shadow-pipe contents and saturating stall counter
    always_comb begin
        pipe_d      = pipe_q;
        stall_cnt_d = stall_cnt_q;
        if (stall_in) begin
            pipe_d      = pipe_q;
            stall_cnt_d = stall_cnt_q;
        end else begin
            for (int k = NUM_FWD_STAGES; k >= 2; k--) begin
                pipe_d[k] = pipe_q[k-1];
            end
            pipe_d[1].valid   = issue & dec_wr_en_s;
            pipe_d[1].dest    = issue ? dec_dest_s : REG_ZERO;
            pipe_d[1].is_load = issue & dec_is_load_s;
            if (hazard_stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 1; k <= NUM_FWD_STAGES; k++) begin
                pipe_q[k] <= '0;
            end
            stall_cnt_q <= 16'd0;
        end else begin
            pipe_q      <= pipe_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_operand_fwd_ctrl.sv
// Scoreboard bench for operand_fwd_ctrl: each driven cycle pushes its
// hand-computed expectation; a negedge monitor pops and compares.
module tb_operand_fwd_ctrl;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        stall_in;
    logic        flush;
    logic [4:0]  ra_addr;
    logic [4:0]  rb_addr;
    logic        ra_used;
    logic        rb_used;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        hazard_stall;
    logic        issue;
    logic [15:0] stall_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        string       name;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        rau;
        logic        rbu;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        chkf;
        logic        hz;
        logic        iss;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    operand_fwd_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_instr     (id_instr),
        .stall_in     (stall_in),
        .flush        (flush),
        .ra_addr      (ra_addr),
        .rb_addr      (rb_addr),
        .ra_used      (ra_used),
        .rb_used      (rb_used),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .hazard_stall (hazard_stall),
        .issue        (issue),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] r_i(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Drive one cycle of inputs, record its expectation, advance past the edge
    task automatic step(input string name, input logic rn, input logic v,
                        input logic [31:0] ins, input logic si, input logic fl,
                        input logic [4:0] ra, input logic [4:0] rb,
                        input logic rau, input logic rbu,
                        input logic [1:0] fa, input logic [1:0] fb, input logic chkf,
                        input logic hz, input logic iss, input logic [15:0] cnt);
        exp_t e;
        rst_n    = rn;
        id_valid = v;
        id_instr = ins;
        stall_in = si;
        flush    = fl;
        e.name = name; e.ra = ra; e.rb = rb; e.rau = rau; e.rbu = rbu;
        e.fa = fa; e.fb = fb; e.chkf = chkf; e.hz = hz; e.iss = iss; e.cnt = cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare one expectation per cycle, away from the active edge
    initial begin
        exp_t e;
        logic ok;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                ok = (ra_used === e.rau) && (rb_used === e.rbu)
                     && (!e.rau || (ra_addr === e.ra)) && (!e.rbu || (rb_addr === e.rb))
                     && (!e.chkf || ((fwd_a === e.fa) && (fwd_b === e.fb)))
                     && (hazard_stall === e.hz) && (issue === e.iss) && (stall_cnt === e.cnt);
                total_cnt++;
                if (ok) begin
                    pass_cnt++;
                end else begin
                    $display("FAIL %s: got ra=%0d/%0b rb=%0d/%0b fwd=%0d,%0d stall=%0b issue=%0b cnt=%0d; want ra=%0d/%0b rb=%0d/%0b fwd=%0d,%0d(chk=%0b) stall=%0b issue=%0b cnt=%0d",
                             e.name, ra_addr, ra_used, rb_addr, rb_used, fwd_a, fwd_b,
                             hazard_stall, issue, stall_cnt, e.ra, e.rau, e.rb, e.rbu,
                             e.fa, e.fb, e.chkf, e.hz, e.iss, e.cnt);
                end
            end
        end
    end

    initial begin
        logic [31:0] add3, sub4, lw5, add6, add7, add0, addi7, or10, sll2, sysc, jal1, jr31;
        logic [31:0] lw11, sub12, add13, or14, lw15, lw16, lw17, add18;
        add3  = r_i(5'd1, 5'd2, 5'd3, 5'd0, 6'b100000);
        sub4  = r_i(5'd3, 5'd1, 5'd4, 5'd0, 6'b100010);
        lw5   = i_i(6'b100011, 5'd1, 5'd5, 16'd0);
        add6  = r_i(5'd5, 5'd5, 5'd6, 5'd0, 6'b100000);
        add7  = r_i(5'd1, 5'd2, 5'd7, 5'd0, 6'b100000);
        add0  = r_i(5'd1, 5'd2, 5'd0, 5'd0, 6'b100000);
        addi7 = i_i(6'b001000, 5'd7, 5'd7, 16'd5);
        or10  = r_i(5'd7, 5'd0, 5'd10, 5'd0, 6'b100101);
        sll2  = r_i(5'd0, 5'd3, 5'd2, 5'd4, 6'b000000);
        sysc  = 32'h0000_000C;
        jal1  = {6'b000011, 26'h000_0100};
        jr31  = r_i(5'd31, 5'd0, 5'd0, 5'd0, 6'b001000);
        lw11  = i_i(6'b100011, 5'd2, 5'd11, 16'd4);
        sub12 = r_i(5'd11, 5'd1, 5'd12, 5'd0, 6'b100010);
        add13 = r_i(5'd12, 5'd12, 5'd13, 5'd0, 6'b100000);
        or14  = r_i(5'd13, 5'd13, 5'd14, 5'd0, 6'b100101);
        lw15  = i_i(6'b100011, 5'd1, 5'd15, 16'd0);
        lw16  = i_i(6'b100011, 5'd2, 5'd16, 16'd0);
        lw17  = i_i(6'b100011, 5'd3, 5'd17, 16'd0);
        add18 = r_i(5'd17, 5'd16, 5'd18, 5'd0, 6'b100000);

        rst_n = 1'b0; id_valid = 1'b0; id_instr = 32'd0; stall_in = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;
        //    name            rn    v     instr  si    fl    ra     rb     rau   rbu   fa    fb    chkf  hz    iss   cnt
        step("reset",        1'b0, 1'b1, add3,  1'b0, 1'b0, 5'd1,  5'd2,  1'b1, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 16'd0);
        step("alu_first",    1'b1, 1'b1, add3,  1'b0, 1'b0, 5'd1,  5'd2,  1'b1, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 16'd0);
        step("alu_b2b",      1'b1, 1'b1, sub4,  1'b0, 1'b0, 5'd3,  5'd1,  1'b1, 1'b1, 2'd1, 2'd0, 1'b1, 1'b0, 1'b1, 16'd0);
        step("lw_issue",     1'b1, 1'b1, lw5,   1'b0, 1'b0, 5'd1,  5'd0,  1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 16'd0);
        step("ld_use_stall", 1'b1, 1'b1, add6,  1'b0, 1'b0, 5'd5,  5'd5,  1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 16'd0);
        step("ld_use_fwd2",  1'b1, 1'b1, add6,  1'b0, 1'b0, 5'd5,  5'd5,  1'b1, 1'b1, 2'd2, 2'd2, 1'b1, 1'b0, 1'b1, 16'd1);
        step("prod7_a",      1'b1, 1'b1, add7,  1'b0, 1'b0, 5'd1,  5'd2,  1'b1, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 16'd1);
        step("dest0",        1'b1, 1'b1, add0,  1'b0, 1'b0, 5'd1,  5'd2,  1'b1, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 16'd1);
        step("addi_fwd2",    1'b1, 1'b1, addi7, 1'b0, 1'b0, 5'd7,  5'd0,  1'b1, 1'b0, 2'd2, 2'd0, 1'b1, 1'b0, 1'b1, 16'd1);
        step("youngest_win", 1'b1, 1'b1, or10,  1'b0, 1'b0, 5'd7,  5'd0,  1'b1, 1'b1, 2'd1, 2'd0, 1'b1, 1'b0, 1'b1, 16'd1);
        step("sll_decode",   1'b1, 1'b1, sll2,  1'b0, 1'b0, 5'd3,  5'd0,  1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 16'd1);
        step("syscall",      1'b1, 1'b1, sysc,  1'b0, 1'b0, 5'd2,  5'd4,  1'b1, 1'b1, 2'd1, 2'd0, 1'b1, 1'b0, 1'b1, 16'd1);
        step("jal_unused",   1'b1, 1'b1, jal1,  1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 16'd1);
        step("jr_ra_fwd",    1'b1, 1'b1, jr31,  1'b0, 1'b0, 5'd31, 5'd0,  1'b1, 1'b0, 2'd1, 2'd0, 1'b1, 1'b0, 1'b1, 16'd1);
        step("lw11",         1'b1, 1'b1, lw11,  1'b0, 1'b0, 5'd2,  5'd0,  1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 16'd1);
        for (int i = 0; i < 3; i++) begin
            step("frz_stall",1'b1, 1'b1, sub12, 1'b1, 1'b0, 5'd11, 5'd1,  1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 16'd1);
        end
        step("unfrz_stall",  1'b1, 1'b1, sub12, 1'b0, 1'b0, 5'd11, 5'd1,  1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 16'd1);
        step("unfrz_fwd2",   1'b1, 1'b1, sub12, 1'b0, 1'b0, 5'd11, 5'd1,  1'b1, 1'b1, 2'd2, 2'd0, 1'b1, 1'b0, 1'b1, 16'd2);
        step("flushed",      1'b1, 1'b1, add13, 1'b0, 1'b1, 5'd12, 5'd12, 1'b1, 1'b1, 2'd1, 2'd1, 1'b1, 1'b0, 1'b0, 16'd2);
        step("after_flush",  1'b1, 1'b1, or14,  1'b0, 1'b0, 5'd13, 5'd13, 1'b1, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 16'd2);
        step("lw15",         1'b1, 1'b1, lw15,  1'b0, 1'b0, 5'd1,  5'd0,  1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 16'd2);
        step("lw16",         1'b1, 1'b1, lw16,  1'b0, 1'b0, 5'd2,  5'd0,  1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 16'd2);
        step("lw17",         1'b1, 1'b1, lw17,  1'b0, 1'b0, 5'd3,  5'd0,  1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 16'd2);
        step("full_ld_stall",1'b1, 1'b1, add18, 1'b0, 1'b0, 5'd17, 5'd16, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 16'd2);
        step("rst_mid",      1'b0, 1'b1, add18, 1'b0, 1'b0, 5'd17, 5'd16, 1'b1, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 16'd3);
        step("post_rst",     1'b1, 1'b1, add18, 1'b0, 1'b0, 5'd17, 5'd16, 1'b1, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 16'd0);

        id_valid = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            total_cnt++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
